// File: rtl/uart_rx_flow.sv
// uart_rx_flow -- UART receive endpoint with FIFO buffering and RTS flow control.
//
// Deserialises 8N1 / 8O1 / 8E1 frames from UART_RXD, checks parity and the
// stop bit, and pushes good bytes into a first-word-fall-through FIFO.
// UART_RTS is driven from the FIFO occupancy with hysteresis so that the far
// end, which gates its transmitter on CTS, pauses before the buffer overruns.
//
// Ports:
//   CLK        clock
//   RST        asynchronous, active-high reset
//   UART_RXD   serial input, idle high, asynchronous to CLK
//   UART_RTS   0 = ready to receive, 1 = far end must pause (registered)
//   RD_DATA    FIFO head byte (0 while the FIFO is empty)
//   RD_VALID   FIFO not empty
//   RD_READY   consumer accepts the head byte
//   FIFO_LEVEL current occupancy, 0..FIFO_DEPTH (registered)
//   PARITY_ERR one-cycle pulse: frame dropped for bad parity
//   FRAME_ERR  one-cycle pulse: frame dropped because the stop bit was low
//   OVERRUN    one-cycle pulse: good frame dropped because the FIFO was full
//   DBG_STATE  receiver FSM state (encoding: see localparams below)
//
// Read handshake: a byte transfers on every rising CLK edge where
// RD_VALID = 1 and RD_READY = 1. RD_VALID never depends on RD_READY, and
// RD_READY is ignored while RD_VALID = 0.

module uart_rx_flow #(
  parameter int CLKS_PER_BIT = 72,
  parameter int P_PARITY     = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int RTS_HI_WM    = 12,
  parameter int RTS_LO_WM    = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          UART_RXD,
  output logic                          UART_RTS,
  output logic [7:0]                    RD_DATA,
  output logic                          RD_VALID,
  input  logic                          RD_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          PARITY_ERR,
  output logic                          FRAME_ERR,
  output logic                          OVERRUN,
  output logic [2:0]                    DBG_STATE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Half a bit period lands the first sample in the middle of the start bit;
  // every later sample is one full bit period after the previous one.
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

  // Value that (data XOR parity bit) must take for a good frame.
  localparam logic PAR_EXPECT = (P_PARITY == 1);

  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [LW-1:0] LEVEL_ONE = 1;
  localparam logic [LW-1:0] HI_WM     = LW'(RTS_HI_WM);
  localparam logic [LW-1:0] LO_WM     = LW'(RTS_LO_WM);

  // ---------------------------------------------------------------------
  // RXD synchroniser (resets to the idle line level)
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= UART_RXD;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bad;
  logic        push_req;
  logic        parity_err_q;
  logic        frame_err_q;
  logic        baud_tick;

  assign baud_tick = (baud_cnt == 16'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      baud_cnt     <= 16'd0;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      par_bad      <= 1'b0;
      push_req     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      push_req     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            baud_cnt <= HALF_LOAD;
          end
        end
        S_START: begin
          if (baud_tick) begin
            if (rxs) begin
              // Line went back high before mid start bit: a glitch.
              state <= S_IDLE;
            end else begin
              state    <= S_DATA;
              baud_cnt <= FULL_LOAD;
              bit_cnt  <= 3'd0;
              par_bad  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            shift    <= {rxs, shift[7:1]};
            baud_cnt <= FULL_LOAD;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= (P_PARITY == 0) ? S_STOP : S_PARITY;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_PARITY: begin
          if (baud_tick) begin
            par_bad  <= (^shift) ^ rxs ^ PAR_EXPECT;
            baud_cnt <= FULL_LOAD;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (baud_tick) begin
            if (!rxs) begin
              // A low stop bit wins over a parity fault.
              frame_err_q <= 1'b1;
              state       <= S_BREAK;
            end else if (par_bad) begin
              parity_err_q <= 1'b1;
              state        <= S_IDLE;
            end else begin
              // shift stays stable until the next frame's first data sample,
              // so the FIFO can take it directly in the following cycle.
              push_req <= 1'b1;
              state    <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so it reports only one framing error.
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign DBG_STATE  = state;
  assign PARITY_ERR = parity_err_q;
  assign FRAME_ERR  = frame_err_q;

  // ---------------------------------------------------------------------
  // FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [LW-1:0] level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          overrun_q;
  logic          rts_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  // Same slot index but opposite wrap bit means the writer lapped the reader.
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && RD_READY;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= shift;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun_q <= 1'b0;
      rts_q     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        level <= level + LEVEL_ONE;
      end else if (!push_ok && pop) begin
        level <= level - LEVEL_ONE;
      end
      overrun_q <= push_req && !push_ok;
      // Hysteresis: follows the registered level, so RTS moves one cycle
      // after the level crosses a watermark and holds in between.
      if (level >= HI_WM) begin
        rts_q <= 1'b1;
      end else if (level <= LO_WM) begin
        rts_q <= 1'b0;
      end
    end
  end

  assign RD_VALID   = !fifo_empty;
  assign RD_DATA    = fifo_empty ? 8'd0 : mem[rd_ptr[AW-1:0]];
  assign FIFO_LEVEL = level;
  assign OVERRUN    = overrun_q;
  assign UART_RTS   = rts_q;

endmodule

// File: tb/tb_uart_rx_flow.sv
// Testbench for uart_rx_flow: drives serial frames on UART_RXD and checks the
// FIFO output, error pulses, occupancy and RTS against a queue-based model.

module tb_uart_rx_flow;

  localparam int CPB   = 72;
  localparam int PAR   = 1;
  localparam int DEPTH = 16;
  localparam int HI    = 12;
  localparam int LO    = 4;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_RXD = 1'b1;
  logic       RD_READY = 1'b0;
  logic       UART_RTS;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic [4:0] FIFO_LEVEL;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic [2:0] DBG_STATE;

  always #5 CLK = ~CLK;

  uart_rx_flow #(
    .CLKS_PER_BIT(CPB),
    .P_PARITY    (PAR),
    .FIFO_DEPTH  (DEPTH),
    .RTS_HI_WM   (HI),
    .RTS_LO_WM   (LO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .UART_RXD  (UART_RXD),
    .UART_RTS  (UART_RTS),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .RD_READY  (RD_READY),
    .FIFO_LEVEL(FIFO_LEVEL),
    .PARITY_ERR(PARITY_ERR),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  exp_q[$];
  int          pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int          exp_pe = 0, exp_fe = 0, exp_ov = 0;
  logic        rts_m = 1'b0;
  bit          rand_ready_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic good_parity(input logic [7:0] b);
    // Odd: ones in data + parity is odd. Even: it is even.
    return (PAR == 1) ? ~(^b) : (^b);
  endfunction

  // Pulse counters and read-side scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (PARITY_ERR) pe_cnt++;
      if (FRAME_ERR)  fe_cnt++;
      if (OVERRUN)    ov_cnt++;
      if (RD_VALID && RD_READY) begin
        if (exp_q.size() == 0) check("pop_with_model_empty", 32'(RD_VALID), 32'd0);
        else                   check("rd_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
      end
    end
  end

  // Random consumer back-pressure.
  always @(posedge CLK) begin
    if (rand_ready_en) begin
      #1 RD_READY = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog.
  initial begin
    repeat (95000) @(posedge CLK);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Sends one frame. The good byte reaches the FIFO on the edge 40 cycles into
  // the stop bit (2-cycle synchroniser, mid-bit sampling, 1-cycle push), so the
  // model is updated right after that edge. pop_at_push pulses RD_READY for
  // exactly that edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit stop_val, input bit pop_at_push);
    @(posedge CLK); #1;
    UART_RXD = 1'b0;
    repeat (CPB) @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      repeat (CPB) @(posedge CLK); #1;
    end
    if (PAR != 0) begin
      UART_RXD = good_parity(b) ^ bad_par;
      repeat (CPB) @(posedge CLK); #1;
    end
    UART_RXD = stop_val;
    if (pop_at_push) begin
      repeat (39) @(posedge CLK); #1;
      RD_READY = 1'b1;
      @(posedge CLK); #1;
      RD_READY = 1'b0;
    end else begin
      repeat (40) @(posedge CLK); #1;
    end
    if (!stop_val)                     exp_fe++;
    else if (PAR != 0 && bad_par)      exp_pe++;
    else if (exp_q.size() == DEPTH)    exp_ov++;
    else                               exp_q.push_back(b);
    repeat (CPB - 40) @(posedge CLK); #1;
  endtask

  task automatic check_status(input string tag);
    if (exp_q.size() >= HI)      rts_m = 1'b1;
    else if (exp_q.size() <= LO) rts_m = 1'b0;
    check({tag, "_parity_err_count"}, 32'(pe_cnt), 32'(exp_pe));
    check({tag, "_frame_err_count"},  32'(fe_cnt), 32'(exp_fe));
    check({tag, "_overrun_count"},    32'(ov_cnt), 32'(exp_ov));
    check({tag, "_level"},            32'(FIFO_LEVEL), 32'(exp_q.size()));
    check({tag, "_rts"},              32'(UART_RTS), 32'(rts_m));
  endtask

  task automatic frame(input string tag, input logic [7:0] b,
                       input bit bad_par, input bit stop_val);
    send_frame(b, bad_par, stop_val, 1'b0);
    check_status(tag);
  endtask

  // One pop; RTS must still hold its old value right after the level moves
  // and take the hysteresis value one cycle later.
  task automatic pop_one(input string tag);
    RD_READY = 1'b1;
    @(posedge CLK); #1;
    RD_READY = 1'b0;
    check({tag, "_level"}, 32'(FIFO_LEVEL), 32'(exp_q.size()));
    check({tag, "_rts_before"}, 32'(UART_RTS), 32'(rts_m));
    @(posedge CLK); #1;
    if (exp_q.size() >= HI)      rts_m = 1'b1;
    else if (exp_q.size() <= LO) rts_m = 1'b0;
    check({tag, "_rts_after"}, 32'(UART_RTS), 32'(rts_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rts"},      32'(UART_RTS),   32'd0);
    check({tag, "_rd_valid"}, 32'(RD_VALID),   32'd0);
    check({tag, "_rd_data"},  32'(RD_DATA),    32'd0);
    check({tag, "_level"},    32'(FIFO_LEVEL), 32'd0);
    check({tag, "_pulses"},   32'({PARITY_ERR, FRAME_ERR, OVERRUN}), 32'd0);
    check({tag, "_state"},    32'(DBG_STATE),  32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------
  initial begin
    int n;
    logic [7:0] b;

    // Reset
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (4) @(posedge CLK);

    // Single frame 0xA5 with RD_VALID latency bounded
    n = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      begin
        while (!RD_VALID && n < 900) begin
          @(posedge CLK);
          n++;
        end
      end
    join
    check("single_valid_latency_ok", 32'(n >= 740 && n <= 800), 32'd1);
    check("single_head", 32'(RD_DATA), 32'hA5);
    check_status("single");
    pop_one("single_pop");

    // Glitch: 20 cycles low, then idle
    @(posedge CLK); #1;
    UART_RXD = 1'b0;
    repeat (20) @(posedge CLK); #1;
    UART_RXD = 1'b1;
    repeat (80) @(posedge CLK); #1;
    check("glitch_state_idle", 32'(DBG_STATE), 32'd0);
    check_status("glitch");
    frame("after_glitch", 8'h3C, 1'b0, 1'b1);
    pop_one("after_glitch_pop");

    // Parity error
    frame("parity_err", 8'h01, 1'b1, 1'b1);

    // Stop bit low, line held low: exactly one FRAME_ERR
    frame("frame_err", 8'h5A, 1'b0, 1'b0);
    repeat (2000) @(posedge CLK); #1;
    UART_RXD = 1'b1;
    repeat (10) @(posedge CLK); #1;
    check("break_single_frame_err", 32'(fe_cnt), 32'(exp_fe));
    frame("after_break", 8'hC3, 1'b0, 1'b1);
    pop_one("after_break_pop");

    // Flow control: fill 0x00..0x0F, then overrun
    for (int i = 0; i < DEPTH; i++) begin
      frame($sformatf("fill_%0d", i), 8'(i), 1'b0, 1'b1);
    end
    frame("overrun", 8'hEE, 1'b0, 1'b1);
    check("overrun_head", 32'(RD_DATA), 32'h00);

    // Push of 0x77 into a full FIFO with a pop on the same edge
    send_frame(8'h77, 1'b0, 1'b1, 1'b1);
    check_status("push_pop_full");
    check("push_pop_full_head", 32'(RD_DATA), 32'h01);

    // Drain in order with RTS hysteresis checks
    for (int i = 0; i < DEPTH; i++) begin
      pop_one($sformatf("drain_%0d", i));
    end
    check("drained_valid", 32'(RD_VALID), 32'd0);

    // Randomized traffic with random consumer back-pressure
    rand_ready_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        frame($sformatf("rand_%0d", i), b, 1'b0, 1'b0);
        UART_RXD = 1'b1;
        repeat (4) @(posedge CLK); #1;
      end else begin
        frame($sformatf("rand_%0d", i), b, ($urandom_range(0, 5) == 0), 1'b1);
      end
    end
    rand_ready_en = 1'b0;
    @(posedge CLK); #2;
    RD_READY = 1'b0;
    while (exp_q.size() != 0) pop_one("rand_drain");

    // Reset during data bit 4 with two bytes buffered
    frame("pre_reset_a", 8'h12, 1'b0, 1'b1);
    frame("pre_reset_b", 8'h34, 1'b0, 1'b1);
    @(posedge CLK); #1;
    UART_RXD = 1'b0;
    repeat (CPB) @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      UART_RXD = 1'(i & 1);
      repeat (CPB) @(posedge CLK); #1;
    end
    UART_RXD = 1'b0;
    repeat (CPB / 2) @(posedge CLK); #1;
    RST = 1'b1;
    exp_q.delete();
    rts_m = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_reset_outputs("mid_frame_reset");
    UART_RXD = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    frame("after_reset", 8'h96, 1'b0, 1'b1);
    check("after_reset_head", 32'(RD_DATA), 32'h96);
    pop_one("after_reset_pop");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
